// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome, 2-bit predictor counter states and
// predictor geometry helpers.
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } BpCounter;

    localparam int BP_INDEX_BITS = 6;

    // Tag covers every PC bit above the index and the word offset.
    function automatic int bp_tag_bits(input int addr_width, input int index_bits);
        return addr_width - index_bits - 2;
    endfunction

    localparam int BP_TAG_BITS = bp_tag_bits(ADDR_WIDTH, BP_INDEX_BITS);

endpackage

// File: rtl/bp_counter_next.sv
// Next 2-bit counter for a resolved branch: saturating step on a tag hit,
// weak allocation state on a miss.
module bp_counter_next
    import mips_core_pkg::*;
(
    input  logic         hit,
    input  BpCounter     counter,
    input  BranchOutcome outcome,
    output BpCounter     counter_next
);

    always_comb begin
        counter_next = WEAK_NT;
        if (!hit) begin
            counter_next = (outcome == TAKEN) ? WEAK_T : WEAK_NT;
        end else if (outcome == TAKEN) begin
            counter_next = (counter == STRONG_T) ? STRONG_T : BpCounter'(counter + 2'd1);
        end else begin
            counter_next = (counter == STRONG_NT) ? STRONG_NT : BpCounter'(counter - 2'd1);
        end
    end

endmodule

// File: rtl/thread_branch_predictor.sv
// Two-thread BTB with 2-bit counters, combinational lookup and a one-deep
// forwarded update stage. Optional statistics under BRANCH_PREDICTOR_STATS_EN.
module thread_branch_predictor
    import mips_core_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_pc_thread_id,
    output logic                  o_pred_valid,
    output logic [ADDR_WIDTH-1:0] o_pred_target,
    output BranchOutcome          o_pred_prediction,
    output logic                  o_pred_thread_id,
    input  logic                  i_res_valid,
    input  logic [ADDR_WIDTH-1:0] i_res_target,
    input  BranchOutcome          i_res_prediction,
    input  BranchOutcome          i_res_outcome,
    input  logic [ADDR_WIDTH-1:0] i_res_pc,
    input  logic                  i_res_thread_id
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0]           o_stat_branches [2],
    output logic [31:0]           o_stat_mispredicts [2]
`endif
);

    localparam int TAG_BITS  = bp_tag_bits(ADDR_WIDTH, INDEX_BITS);
    localparam int ADDR_BITS = INDEX_BITS + 1;
    localparam int DEPTH     = 1 << ADDR_BITS;

    typedef struct packed {
        logic                  valid;
        logic [TAG_BITS-1:0]   tag;
        logic [ADDR_WIDTH-1:0] target;
        BpCounter              ctr;
    } entry_t;

    entry_t                table_q [DEPTH];

    logic                  u_valid;
    logic [ADDR_BITS-1:0]  u_addr;
    entry_t                u_entry;

    logic [ADDR_BITS-1:0]  res_addr;
    logic [TAG_BITS-1:0]   res_tag;
    logic                  res_fwd;
    entry_t                arr_base;
    logic                  arr_hit;
    logic                  fwd_hit;
    BpCounter              arr_ctr_next;
    BpCounter              fwd_ctr_next;
    entry_t                res_entry;

    logic [ADDR_BITS-1:0]  pc_addr;
    logic [TAG_BITS-1:0]   pc_tag;
    entry_t                look;
    logic                  look_hit;

    assign res_addr = {i_res_thread_id, i_res_pc[INDEX_BITS+1:2]};
    assign res_tag  = i_res_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign res_fwd  = u_valid && (u_addr == res_addr);
    assign arr_base = table_q[res_addr];
    assign arr_hit  = arr_base.valid && (arr_base.tag == res_tag);
    assign fwd_hit  = u_entry.valid && (u_entry.tag == res_tag);

    bp_counter_next u_arr_next (
        .hit          (arr_hit),
        .counter      (arr_base.ctr),
        .outcome      (i_res_outcome),
        .counter_next (arr_ctr_next)
    );

    // A resolution hitting the pending entry must build on its new value.
    bp_counter_next u_fwd_next (
        .hit          (fwd_hit),
        .counter      (u_entry.ctr),
        .outcome      (i_res_outcome),
        .counter_next (fwd_ctr_next)
    );

    always_comb begin
        res_entry        = '0;
        res_entry.valid  = 1'b1;
        res_entry.tag    = res_tag;
        res_entry.target = i_res_target;
        res_entry.ctr    = res_fwd ? fwd_ctr_next : arr_ctr_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            u_valid <= 1'b0;
        end else begin
            u_valid <= i_res_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_res_valid) begin
            u_addr  <= res_addr;
            u_entry <= res_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i].valid <= 1'b0;
                table_q[i].ctr   <= WEAK_NT;
            end
        end else if (u_valid) begin
            table_q[u_addr] <= u_entry;
        end
    end

    assign pc_addr = {i_pc_thread_id, i_pc[INDEX_BITS+1:2]};
    assign pc_tag  = i_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign look    = (u_valid && (u_addr == pc_addr)) ? u_entry : table_q[pc_addr];
    // Outputs are forced quiet while reset is asserted, before the array clears.
    assign look_hit = !rst && look.valid && (look.tag == pc_tag);

    assign o_pred_valid      = look_hit;
    assign o_pred_target     = look_hit ? look.target : '0;
    assign o_pred_prediction = (look_hit && look.ctr[1]) ? TAKEN : NOT_TAKEN;
    assign o_pred_thread_id  = i_pc_thread_id;

`ifdef BRANCH_PREDICTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < 2; t++) begin
                o_stat_branches[t]    <= '0;
                o_stat_mispredicts[t] <= '0;
            end
        end else if (i_res_valid) begin
            if (o_stat_branches[i_res_thread_id] != 32'hFFFF_FFFF) begin
                o_stat_branches[i_res_thread_id] <= o_stat_branches[i_res_thread_id] + 32'd1;
            end
            if ((i_res_prediction != i_res_outcome) &&
                (o_stat_mispredicts[i_res_thread_id] != 32'hFFFF_FFFF)) begin
                o_stat_mispredicts[i_res_thread_id] <= o_stat_mispredicts[i_res_thread_id] + 32'd1;
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_pc[1:0], i_res_pc[1:0]};
`else
    logic unused_inputs;
    assign unused_inputs = ^{i_pc[1:0], i_res_pc[1:0], i_res_prediction};
`endif

endmodule

// File: tb/tb_thread_branch_predictor.sv
// Self-checking bench for thread_branch_predictor: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_thread_branch_predictor;
    import mips_core_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_pc;
    logic         i_pc_thread_id;
    logic         o_pred_valid;
    logic [31:0]  o_pred_target;
    BranchOutcome o_pred_prediction;
    logic         o_pred_thread_id;
    logic         i_res_valid;
    logic [31:0]  i_res_target;
    BranchOutcome i_res_prediction;
    BranchOutcome i_res_outcome;
    logic [31:0]  i_res_pc;
    logic         i_res_thread_id;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0]  stat_br [2];
    logic [31:0]  stat_mp [2];
`endif

    always #5 clk = ~clk;

    thread_branch_predictor dut (
        .clk               (clk),
        .rst               (rst),
        .i_pc              (i_pc),
        .i_pc_thread_id    (i_pc_thread_id),
        .o_pred_valid      (o_pred_valid),
        .o_pred_target     (o_pred_target),
        .o_pred_prediction (o_pred_prediction),
        .o_pred_thread_id  (o_pred_thread_id),
        .i_res_valid       (i_res_valid),
        .i_res_target      (i_res_target),
        .i_res_prediction  (i_res_prediction),
        .i_res_outcome     (i_res_outcome),
        .i_res_pc          (i_res_pc),
        .i_res_thread_id   (i_res_thread_id)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .o_stat_branches   (stat_br),
        .o_stat_mispredicts(stat_mp)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: what each thread's table should hold once every
    // accepted resolution has taken effect.
    bit          m_valid  [2][64];
    int unsigned m_tag    [2][64];
    int unsigned m_target [2][64];
    int          m_ctr    [2][64];
    int unsigned m_br     [2];
    int unsigned m_mp     [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int t = 0; t < 2; t++) begin
            m_br[t] = 0;
            m_mp[t] = 0;
            for (int i = 0; i < 64; i++) begin
                m_valid[t][i] = 1'b0;
                m_ctr[t][i]   = 1;
            end
        end
    endfunction

    function automatic void model_update(input logic [31:0] pc, input bit t,
                                         input logic [31:0] tgt, input bit taken, input bit pred);
        int idx;
        int unsigned tg;
        idx = int'((pc >> 2) % 64);
        tg  = pc >> 8;
        if (m_valid[t][idx] && m_tag[t][idx] == tg) begin
            m_target[t][idx] = tgt;
            if (taken) m_ctr[t][idx] = (m_ctr[t][idx] == 3) ? 3 : m_ctr[t][idx] + 1;
            else       m_ctr[t][idx] = (m_ctr[t][idx] == 0) ? 0 : m_ctr[t][idx] - 1;
        end else begin
            m_valid[t][idx]  = 1'b1;
            m_tag[t][idx]    = tg;
            m_target[t][idx] = tgt;
            m_ctr[t][idx]    = taken ? 2 : 1;
        end
        m_br[t]++;
        if (pred != taken) m_mp[t]++;
    endfunction

    // One cycle: drive inputs, check the lookup, then let the edge commit.
    task automatic step(input bit r, input logic [31:0] pc, input bit pt,
                        input bit rv, input logic [31:0] rpc, input bit rt,
                        input logic [31:0] rtgt, input bit taken, input bit pred);
        int idx;
        bit hit;
        @(negedge clk);
        rst              = r;
        i_pc             = pc;
        i_pc_thread_id   = pt;
        i_res_valid      = rv;
        i_res_pc         = rpc;
        i_res_thread_id  = rt;
        i_res_target     = rtgt;
        i_res_outcome    = BranchOutcome'(taken);
        i_res_prediction = BranchOutcome'(pred);
        #1;
        idx = int'((pc >> 2) % 64);
        hit = !r && m_valid[pt][idx] && (m_tag[pt][idx] == (pc >> 8));
        check("pred_valid", {31'd0, o_pred_valid}, {31'd0, hit});
        check("pred_target", o_pred_target, hit ? m_target[pt][idx] : 32'd0);
        check("pred_taken", {31'd0, o_pred_prediction}, {31'd0, hit && m_ctr[pt][idx] >= 2});
        check("pred_thread", {31'd0, o_pred_thread_id}, {31'd0, pt});
        @(posedge clk);
        if (r) model_reset();
        else if (rv) model_update(rpc, rt, rtgt, taken, pred);
    endtask

    task automatic look(input logic [31:0] pc, input bit pt);
        step(1'b0, pc, pt, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic [31:0] rpc, input bit rt, input logic [31:0] rtgt,
                           input bit taken, input logic [31:0] pc, input bit pt);
        step(1'b0, pc, pt, 1'b1, rpc, rt, rtgt, taken, taken);
    endtask

    task automatic do_reset();
        step(1'b1, 32'h0040_0010, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h0040_0010, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tags [3];
        logic [31:0] idxs [3];
        tags[0] = 32'h4000; tags[1] = 32'h4010; tags[2] = 32'h4020;
        idxs[0] = 32'd4;    idxs[1] = 32'd5;    idxs[2] = 32'd63;
        return (tags[$urandom_range(2, 0)] << 8) | (idxs[$urandom_range(2, 0)] << 2) |
               32'($urandom_range(3, 0));
    endfunction

    initial begin
        model_reset();
        rst = 1'b1; i_pc = '0; i_pc_thread_id = 1'b0; i_res_valid = 1'b0;
        i_res_target = '0; i_res_pc = '0; i_res_thread_id = 1'b0;
        i_res_outcome = NOT_TAKEN; i_res_prediction = NOT_TAKEN;

        do_reset();
        look(32'h0040_0010, 1'b0);
        look(32'h0040_0010, 1'b1);

        // First allocation, seen by forwarding then from the array.
        resolve(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0010, 1'b0);
        look(32'h0040_0010, 1'b0);
        look(32'h0040_0010, 1'b0);
        look(32'h0040_0010, 1'b1);

        // Saturation and decay on one entry with back-to-back forwarding.
        for (int i = 0; i < 4; i++)
            resolve(32'h0040_0020, 1'b1, 32'h0040_0200 + 32'(i), 1'b1, 32'h0040_0020, 1'b1);
        for (int i = 0; i < 2; i++)
            resolve(32'h0040_0020, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0020, 1'b1);
        look(32'h0040_0020, 1'b1);
        check("ctr_after_decay_nt", {31'd0, o_pred_prediction}, {31'd0, NOT_TAKEN});

        // Same index, different tag replaces the entry.
        resolve(32'h0040_1010, 1'b0, 32'h0040_2000, 1'b1, 32'h0040_0010, 1'b0);
        look(32'h0040_0010, 1'b0);
        look(32'h0040_1010, 1'b0);

        // Reset while an update is pending drops it.
        resolve(32'h0040_0030, 1'b0, 32'h0040_0400, 1'b1, 32'h0040_0030, 1'b0);
        step(1'b1, 32'h0040_0030, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        look(32'h0040_0030, 1'b0);
        check("pending_dropped", {31'd0, o_pred_valid}, 32'd0);

        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(99, 0) == 0), rand_pc(), 1'($urandom_range(1, 0)),
                 1'($urandom_range(3, 0) != 0), rand_pc(), 1'($urandom_range(1, 0)),
                 $urandom, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

`ifdef BRANCH_PREDICTOR_STATS_EN
        check("rand_br0", stat_br[0], m_br[0]);
        check("rand_mp1", stat_mp[1], m_mp[1]);
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1'b0, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0800,
                 1'b1, (i < 3) ? 1'b0 : 1'b1);
        look(32'h0040_0010, 1'b0);
        check("stat_br1", stat_br[1], 32'd10);
        check("stat_mp1", stat_mp[1], 32'd3);
        check("stat_br0", stat_br[0], 32'd0);
        check("stat_mp0", stat_mp[0], 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/thread_branch_predictor.md
# thread_branch_predictor

Two-thread branch predictor that drives `branch_prediction_ifc` toward fetch and consumes `branch_resolution_ifc` from decode. It holds one direct-mapped BTB and 2-bit counter table per thread. Fetch looks up the current PC combinationally. Decode resolutions are registered, then committed one cycle later, with forwarding so back-to-back updates and lookups see the newest state.

## Interface
- `INDEX_BITS`, default 6: entries per thread = 2^INDEX_BITS.
- `clk  input  1`: core clock.
- `rst  input  1`: synchronous, active-high reset.
- `i_pc  input  ADDR_WIDTH`: fetch PC being looked up (from `pc_ifc`).
- `i_pc_thread_id  input  1`: thread of `i_pc`.
- `o_pred_valid  output  1`: BTB hit; PC is a known branch/jump.
- `o_pred_target  output  ADDR_WIDTH`: predicted target.
- `o_pred_prediction  output  BranchOutcome`: TAKEN/NOT_TAKEN.
- `o_pred_thread_id  output  1`: equals `i_pc_thread_id`.
- `i_res_valid  input  1`: decode resolved a branch/jump this cycle.
- `i_res_target  input  ADDR_WIDTH`: decoded target.
- `i_res_prediction  input  BranchOutcome`: what was predicted (stats only).
- `i_res_outcome  input  BranchOutcome`: evaluated decision.
- `i_res_pc  input  ADDR_WIDTH`: PC of the resolved instruction.
- `i_res_thread_id  input  1`: thread of the resolved instruction.

## Operation
- Entry: valid, tag = pc[ADDR_WIDTH-1:INDEX_BITS+2], target, 2-bit counter. Index = pc[INDEX_BITS+1:2]. Table address = {thread_id, index}.
- Lookup is combinational:
  - hit = entry valid and tag equal.
  - `o_pred_valid` = hit.
  - `o_pred_target` = entry target when hit, else 0.
  - `o_pred_prediction` = TAKEN iff hit and counter[1] = 1.
- Update stage U:
  - `i_res_valid` registers res_pc, thread, target, and outcome into U (`u_valid`).
  - On the next edge U writes the entry:
    - Tag match: keep tag, overwrite target, saturating-update the counter (+1 on TAKEN, −1 on NOT_TAKEN, clamp 0..3).
    - Miss or invalid: allocate by setting valid, tag, and target. Counter = WEAK_T (2) if TAKEN, else WEAK_NT (1).
- Forwarding:
  - A lookup matching U's address uses U's computed next entry.
  - A resolution matching U's address computes its update from U's next entry, not the stale array.
- Resolutions always commit; flushes and stalls do not cancel U.
- Threads never alias: a thread-0 update is invisible to thread-1 lookups at the same index.

## Timing
- Lookup latency: 0 cycles.
- Resolution in cycle N: U valid in N+1; array written at end of N+1. Lookups in N+1 see it via forwarding; from N+2 they see it from the array.
- One resolution accepted per cycle, every cycle; no backpressure.
- Reset (synchronous, any cycle): all valid bits cleared, counters set to WEAK_NT, `u_valid` cleared (pending update dropped).
- Output values during and after reset: `o_pred_valid`=0, `o_pred_target`=0, `o_pred_prediction`=NOT_TAKEN, `o_pred_thread_id`=`i_pc_thread_id`.
- Counter saturation: STRONG_T + TAKEN stays 3; STRONG_NT + NOT_TAKEN stays 0.

## Configuration
- `BRANCH_PREDICTOR_STATS_EN` defined:
  - Adds per-thread 32-bit `o_stat_branches[2]` and `o_stat_mispredicts[2]`, both reset to 0.
  - On each `i_res_valid`, branches[thread] increments.
  - mispredicts[thread] increments when `i_res_prediction` != `i_res_outcome`.
  - Both counters saturate at 0xFFFF_FFFF.
- Undefined: these ports and counters do not exist; `i_res_prediction` is unused.

## Structure
- Package `mips_core_pkg` gains `BpCounter` enum: STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3. It also gains `BP_TAG_BITS`, derived from ADDR_WIDTH and INDEX_BITS via a function.
- Sub-module `bp_counter_next`: combinational (hit, current counter, outcome) → next counter. It is instantiated for both the U path and the forwarding path.

## Test plan
- Reset, then lookup pc 0x400010 on both threads → `o_pred_valid`=0, prediction NOT_TAKEN.
- Resolve thread 0 pc 0x400010, TAKEN, target 0x400100; lookup in N+1 and N+2 → valid=1, target 0x400100, TAKEN. Thread 1 at the same pc → valid=0.
- Four consecutive TAKEN resolutions on one entry, then two NOT_TAKEN → counter 2→3→3→3, then 2, 1. Last lookup predicts NOT_TAKEN; forwarding is exercised every cycle.
- Conflict: pc 0x400010 then 0x401010 (same index, different tag), both TAKEN → second replaces the first. Lookup of 0x400010 misses.
- Assert `rst` in the cycle U holds a pending update → after reset, lookup of that pc misses.
- With `BRANCH_PREDICTOR_STATS_EN`: 10 thread-1 resolutions, 3 with prediction != outcome → branches[1]=10, mispredicts[1]=3, thread-0 counters 0.
